// File: rtl/dep_clk_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : dep_clk_edge_monitor
// Brief    : Samples a dependent clock in the clk domain and detects its edges.
//            It counts the edges and checks that consecutive edges are exactly
//            PERIOD cycles apart. It flags completion after TARGET edges. It
//            raises sticky errors on a spacing violation or on a stalled
//            dependent clock.
// Revision : 1.0 - initial release
// ============================================================================
module dep_clk_edge_monitor #(
   parameter int CNT_W   = 8,
   parameter int TARGET  = 20,
   parameter int PERIOD  = 1,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dep_clk,
   output logic             edge_valid,
   output logic             edge_rise,
   output logic [CNT_W-1:0] edge_count,
   output logic             gap_err,
   output logic             stall_err,
   output logic             done,
   output logic             busy
);

   // State encoding. DONE and FAIL are terminal until en drops or rst.
   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_ARM  = 3'd1;
   localparam logic [2:0] c_RUN  = 3'd2;
   localparam logic [2:0] c_DONE = 3'd3;
   localparam logic [2:0] c_FAIL = 3'd4;

   localparam logic [CNT_W-1:0] c_ZERO    = '0;
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_TARGET  = CNT_W'(TARGET);
   localparam logic [CNT_W-1:0] c_PERIOD  = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_ALL1    = '1;

   // Registered state.
   logic [2:0]       r_state;
   logic             r_prev;
   logic [CNT_W-1:0] r_gap;
   logic             r_edge_valid;
   logic             r_edge_rise;
   logic [CNT_W-1:0] r_edge_count;
   logic             r_gap_err;
   logic             r_stall_err;
   logic             r_done;
   logic             r_busy;

   // Next-state values.
   logic [2:0]       w_state_nxt;
   logic             w_prev_nxt;
   logic [CNT_W-1:0] w_gap_nxt;
   logic             w_edge_valid_nxt;
   logic             w_edge_rise_nxt;
   logic [CNT_W-1:0] w_edge_count_nxt;
   logic             w_gap_err_nxt;
   logic             w_stall_err_nxt;
   logic             w_done_nxt;
   logic             w_busy_nxt;

   // Shared decode.
   logic             w_edge;
   logic [CNT_W-1:0] w_gap_inc;
   logic             w_stall;
   logic             w_gap_ok;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_cnt_hit;

   // Edges are only meaningful once armed. In IDLE, prev is (re)loaded, so
   // a toggle coinciding with arming is absorbed and never counted.
   assign w_edge    = (dep_clk != r_prev) && (r_state != c_IDLE);
   // Gap counter saturates so a long wait can never wrap back to PERIOD.
   assign w_gap_inc = (r_gap == c_ALL1) ? r_gap : (r_gap + c_ONE);
   // A stall is declared when the incremented gap reaches TIMEOUT.
   assign w_stall   = (w_gap_inc == c_TIMEOUT);
   assign w_gap_ok  = (r_gap == c_PERIOD);
   assign w_cnt_inc = r_edge_count + c_ONE;
   assign w_cnt_hit = (w_cnt_inc == c_TARGET);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. Dropping en wins over everything except reset.
   // An edge takes priority over a same-cycle stall. A bad edge takes
   // priority over reaching TARGET.
   always_comb begin
      w_state_nxt = r_state;
      if (!en) begin
         w_state_nxt = c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: w_state_nxt = c_ARM;
            c_ARM: begin
               if (w_edge) begin
                  w_state_nxt = (c_TARGET == c_ONE) ? c_DONE : c_RUN;
               end else if (w_stall) begin
                  w_state_nxt = c_FAIL;
               end
            end
            c_RUN: begin
               if (w_edge) begin
                  if (!w_gap_ok) begin
                     w_state_nxt = c_FAIL;
                  end else if (w_cnt_hit) begin
                     w_state_nxt = c_DONE;
                  end
               end else if (w_stall) begin
                  w_state_nxt = c_FAIL;
               end
            end
            c_DONE:  w_state_nxt = c_DONE;
            c_FAIL:  w_state_nxt = c_FAIL;
            default: w_state_nxt = c_IDLE;
         endcase
      end
   end

   // Datapath and flag next values. Every output is registered from these.
   always_comb begin
      w_prev_nxt       = en ? dep_clk : r_prev;
      w_gap_nxt        = r_gap;
      w_edge_count_nxt = r_edge_count;
      w_gap_err_nxt    = r_gap_err;
      w_stall_err_nxt  = r_stall_err;
      w_done_nxt       = r_done;
      w_edge_valid_nxt = 1'b0;
      w_edge_rise_nxt  = 1'b0;
      w_busy_nxt       = (w_state_nxt == c_ARM) || (w_state_nxt == c_RUN);
      if (en) begin
         // Edge pulses continue in the terminal states.
         w_edge_valid_nxt = w_edge;
         w_edge_rise_nxt  = w_edge & dep_clk;
         case (r_state)
            c_IDLE: begin
               w_gap_nxt        = c_ZERO;
               w_edge_count_nxt = c_ZERO;
               w_gap_err_nxt    = 1'b0;
               w_stall_err_nxt  = 1'b0;
               w_done_nxt       = 1'b0;
            end
            c_ARM: begin
               if (w_edge) begin
                  // The first edge has no reference, so it is not gap-checked.
                  w_edge_count_nxt = c_ONE;
                  w_gap_nxt        = c_ONE;
                  if (c_TARGET == c_ONE) begin
                     w_done_nxt = 1'b1;
                  end
               end else begin
                  w_gap_nxt = w_gap_inc;
                  if (w_stall) begin
                     w_stall_err_nxt = 1'b1;
                  end
               end
            end
            c_RUN: begin
               if (w_edge) begin
                  w_gap_nxt = c_ONE;
                  if (!w_gap_ok) begin
                     w_gap_err_nxt = 1'b1;
                  end else begin
                     w_edge_count_nxt = w_cnt_inc;
                     if (w_cnt_hit) begin
                        w_done_nxt = 1'b1;
                     end
                  end
               end else begin
                  w_gap_nxt = w_gap_inc;
                  if (w_stall) begin
                     w_stall_err_nxt = 1'b1;
                  end
               end
            end
            default: begin
               // DONE / FAIL: counters and flags frozen.
            end
         endcase
      end
   end

   // Datapath registers. Reset returns every output to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev       <= 1'b0;
         r_gap        <= c_ZERO;
         r_edge_valid <= 1'b0;
         r_edge_rise  <= 1'b0;
         r_edge_count <= c_ZERO;
         r_gap_err    <= 1'b0;
         r_stall_err  <= 1'b0;
         r_done       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_prev       <= w_prev_nxt;
         r_gap        <= w_gap_nxt;
         r_edge_valid <= w_edge_valid_nxt;
         r_edge_rise  <= w_edge_rise_nxt;
         r_edge_count <= w_edge_count_nxt;
         r_gap_err    <= w_gap_err_nxt;
         r_stall_err  <= w_stall_err_nxt;
         r_done       <= w_done_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign edge_valid = r_edge_valid;
   assign edge_rise  = r_edge_rise;
   assign edge_count = r_edge_count;
   assign gap_err    = r_gap_err;
   assign stall_err  = r_stall_err;
   assign done       = r_done;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dep_clk_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_dep_clk_edge_monitor
// Brief    : Bench for dep_clk_edge_monitor. Two instances share the stimulus:
//            inst0 uses PERIOD=1 and inst1 uses PERIOD=2. A timestamp-based
//            reference model predicts both instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dep_clk_edge_monitor;

   localparam int CNT_W   = 8;
   localparam int TARGET  = 20;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst, en, dep_clk;

   logic             ev0, er0, ge0, se0, dn0, bz0;
   logic [CNT_W-1:0] cnt0;
   logic             ev1, er1, ge1, se1, dn1, bz1;
   logic [CNT_W-1:0] cnt1;

   always #5 clk = ~clk;

   dep_clk_edge_monitor #(.CNT_W(CNT_W), .TARGET(TARGET), .PERIOD(1), .TIMEOUT(TIMEOUT)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .dep_clk(dep_clk),
      .edge_valid(ev0), .edge_rise(er0), .edge_count(cnt0),
      .gap_err(ge0), .stall_err(se0), .done(dn0), .busy(bz0)
   );

   dep_clk_edge_monitor #(.CNT_W(CNT_W), .TARGET(TARGET), .PERIOD(2), .TIMEOUT(TIMEOUT)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .dep_clk(dep_clk),
      .edge_valid(ev1), .edge_rise(er1), .edge_count(cnt1),
      .gap_err(ge1), .stall_err(se1), .done(dn1), .busy(bz1)
   );

   // Observed output bundles; edge_rise is only meaningful with edge_valid.
   logic [13:0] obs [2];
   assign obs[0] = {ev0, ev0 & er0, cnt0, ge0, se0, dn0, bz0};
   assign obs[1] = {ev1, ev1 & er1, cnt1, ge1, se1, dn1, bz1};

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   logic d    = 1'b0;

   // Reference model: tracks the arm/edge timestamps instead of a gap counter.
   bit               m_armed  [2];
   bit               m_active [2];
   bit               m_seen   [2];
   logic             m_prev   [2];
   int               m_ref    [2];
   logic             x_ev [2], x_er [2], x_ge [2], x_se [2], x_dn [2], x_bz [2];
   logic [CNT_W-1:0] x_cnt [2];

   function automatic int period_of(input int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic [13:0] expv(input int i);
      return {x_ev[i], x_ev[i] & x_er[i], x_cnt[i], x_ge[i], x_se[i], x_dn[i], x_bz[i]};
   endfunction

   // The elapsed gap at cycle t is t - m_ref. Arming sets m_ref to the arm
   // cycle, so the gap is 0. An edge at cycle e sets m_ref to e-1, so the gap
   // is 1.
   task automatic model_step(input int i, input logic r, input logic e, input logic dv);
      bit edge_seen;
      if (r) begin
         m_armed[i] = 0; m_active[i] = 0; m_seen[i] = 0; m_prev[i] = 1'b0; m_ref[i] = 0;
         x_ev[i] = 0; x_er[i] = 0; x_cnt[i] = '0; x_ge[i] = 0; x_se[i] = 0; x_dn[i] = 0; x_bz[i] = 0;
      end else if (!e) begin
         m_armed[i] = 0; m_active[i] = 0;
         x_ev[i] = 0; x_er[i] = 0; x_bz[i] = 0;
      end else if (!m_armed[i]) begin
         m_armed[i] = 1; m_active[i] = 1; m_seen[i] = 0; m_prev[i] = dv; m_ref[i] = cyc;
         x_ev[i] = 0; x_er[i] = 0; x_cnt[i] = '0; x_ge[i] = 0; x_se[i] = 0; x_dn[i] = 0; x_bz[i] = 1;
      end else begin
         edge_seen = (dv != m_prev[i]);
         m_prev[i] = dv;
         x_ev[i]   = edge_seen;
         x_er[i]   = edge_seen & dv;
         if (m_active[i]) begin
            if (edge_seen) begin
               if (!m_seen[i]) begin
                  m_seen[i] = 1;
                  x_cnt[i]  = 1;
               end else if ((cyc - 1 - m_ref[i]) != period_of(i)) begin
                  x_ge[i] = 1; m_active[i] = 0;
               end else begin
                  x_cnt[i] = x_cnt[i] + 1'b1;
               end
               if (m_active[i] && (int'(x_cnt[i]) == TARGET)) begin
                  x_dn[i] = 1; m_active[i] = 0;
               end
               m_ref[i] = cyc - 1;
            end else if ((cyc - m_ref[i]) >= TIMEOUT) begin
               x_se[i] = 1; m_active[i] = 0;
            end
         end
         x_bz[i] = m_active[i];
      end
   endtask

   // Drive one cycle of inputs, advance the model, and land on the next negedge.
   task automatic tick(input logic r, input logic e, input logic dv);
      rst = r; en = e; dep_clk = dv;
      model_step(0, r, e, dv);
      model_step(1, r, e, dv);
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset;
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      d = 1'b0;
      n_chk++;
      if (obs[0] !== 14'h0) $display("FAIL reset_inst0: got %h expected %h", obs[0], 14'h0);
      else n_pass++;
      n_chk++;
      if (obs[1] !== 14'h0) $display("FAIL reset_inst1: got %h expected %h", obs[1], 14'h0);
      else n_pass++;
   endtask

   task automatic test_toggle_run;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      n_chk++;
      if (bz0 !== 1'b1) $display("FAIL busy_after_arm: got %b expected 1", bz0);
      else n_pass++;
      for (int k = 1; k <= TARGET; k++) begin
         d = ~d;
         tick(1'b0, 1'b1, d);
         n_chk++;
         if ({ev0, er0, cnt0, dn0} !== {1'b1, d, CNT_W'(k), (k == TARGET)})
            $display("FAIL toggle_edge%0d: got v=%b r=%b c=%0d d=%b expected v=1 r=%b c=%0d d=%b",
                     k, ev0, er0, cnt0, dn0, d, k, (k == TARGET));
         else n_pass++;
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== expv(i)) $display("FAIL toggle_model inst%0d cyc%0d: got %h expected %h", i, cyc, obs[i], expv(i));
            else n_pass++;
         end
      end
      n_chk++;
      if ({ge0, se0, ge1, cnt1} !== {1'b0, 1'b0, 1'b1, CNT_W'(1)})
         $display("FAIL toggle_flags: got ge0=%b se0=%b ge1=%b cnt1=%0d expected 0 0 1 1", ge0, se0, ge1, cnt1);
      else n_pass++;
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({ev0, cnt0, dn0, bz0} !== {1'b1, CNT_W'(TARGET), 1'b1, 1'b0})
         $display("FAIL done_frozen: got v=%b c=%0d d=%b b=%b expected 1 %0d 1 0", ev0, cnt0, dn0, bz0, TARGET);
      else n_pass++;
   endtask

   task automatic test_gap_err;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) tick(1'b0, 1'b1, d);
         d = ~d;
         tick(1'b0, 1'b1, d);
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== expv(i)) $display("FAIL gap_model inst%0d cyc%0d: got %h expected %h", i, cyc, obs[i], expv(i));
            else n_pass++;
         end
      end
      tick(1'b0, 1'b1, d);
      tick(1'b0, 1'b1, d);
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({ev1, cnt1, ge1, se1, dn1, bz1} !== {1'b1, CNT_W'(6), 1'b1, 1'b0, 1'b0, 1'b0})
         $display("FAIL gap_err_edge7: got v=%b c=%0d ge=%b se=%b d=%b b=%b expected 1 6 1 0 0 0",
                  ev1, cnt1, ge1, se1, dn1, bz1);
      else n_pass++;
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({ev1, cnt1, ge1} !== {1'b1, CNT_W'(6), 1'b1})
         $display("FAIL fail_frozen: got v=%b c=%0d ge=%b expected 1 6 1", ev1, cnt1, ge1);
      else n_pass++;
   endtask

   task automatic test_stall;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= TIMEOUT; k++) begin
         tick(1'b0, 1'b1, d);
         if (k == TIMEOUT - 1) begin
            n_chk++;
            if (se0 !== 1'b0) $display("FAIL stall_early: got %b expected 0", se0);
            else n_pass++;
         end
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== expv(i)) $display("FAIL stall_model inst%0d cyc%0d: got %h expected %h", i, cyc, obs[i], expv(i));
            else n_pass++;
         end
      end
      n_chk++;
      if ({se0, se1, dn0, bz0, ge0} !== 5'b11000)
         $display("FAIL stall_at_timeout: got se0=%b se1=%b d=%b b=%b ge=%b expected 1 1 0 0 0", se0, se1, dn0, bz0, ge0);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= 10; k++) begin
         d = ~d;
         tick(1'b0, 1'b1, d);
      end
      d = ~d;
      tick(1'b1, 1'b1, d);
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if (obs[i] !== 14'h0) $display("FAIL reset_mid inst%0d: got %h expected %h", i, obs[i], 14'h0);
         else n_pass++;
      end
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= TARGET; k++) begin
         d = ~d;
         tick(1'b0, 1'b1, d);
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== expv(i)) $display("FAIL rearm_model inst%0d cyc%0d: got %h expected %h", i, cyc, obs[i], expv(i));
            else n_pass++;
         end
      end
      n_chk++;
      if ({cnt0, dn0, ge0, se0} !== {CNT_W'(TARGET), 3'b100})
         $display("FAIL rearm_done: got c=%0d d=%b ge=%b se=%b expected %0d 1 0 0", cnt0, dn0, ge0, se0, TARGET);
      else n_pass++;
   endtask

   task automatic test_en_drop;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= 5; k++) begin
         d = ~d;
         tick(1'b0, 1'b1, d);
      end
      tick(1'b0, 1'b0, d);
      n_chk++;
      if ({cnt0, bz0, ev0} !== {CNT_W'(5), 2'b00})
         $display("FAIL en_drop_hold: got c=%0d b=%b v=%b expected 5 0 0", cnt0, bz0, ev0);
      else n_pass++;
      d = ~d;
      tick(1'b0, 1'b0, d);
      n_chk++;
      if ({cnt0, ev0} !== {CNT_W'(5), 1'b0})
         $display("FAIL idle_toggle: got c=%0d v=%b expected 5 0", cnt0, ev0);
      else n_pass++;
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({cnt0, bz0} !== {CNT_W'(0), 1'b1})
         $display("FAIL rearm_clear: got c=%0d b=%b expected 0 1", cnt0, bz0);
      else n_pass++;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if (ev0 !== 1'b0) $display("FAIL absorbed_edge: got v=%b expected 0", ev0);
      else n_pass++;
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({ev0, cnt0} !== {1'b1, CNT_W'(1)})
         $display("FAIL first_after_rearm: got v=%b c=%0d expected 1 1", ev0, cnt0);
      else n_pass++;
   endtask

   task automatic test_timeout_edge;
      tick(1'b0, 1'b0, d);
      tick(1'b0, 1'b1, d);
      d = ~d;
      tick(1'b0, 1'b1, d);
      for (int k = 1; k <= TIMEOUT - 2; k++) tick(1'b0, 1'b1, d);
      d = ~d;
      tick(1'b0, 1'b1, d);
      n_chk++;
      if ({ev0, ge0, se0, cnt0} !== {3'b110, CNT_W'(1)})
         $display("FAIL timeout_edge: got v=%b ge=%b se=%b c=%0d expected 1 1 0 1", ev0, ge0, se0, cnt0);
      else n_pass++;
      n_chk++;
      if (obs[1] !== expv(1)) $display("FAIL timeout_edge_inst1: got %h expected %h", obs[1], expv(1));
      else n_pass++;
   endtask

   task automatic test_random;
      int mode;
      logic r, e;
      tick(1'b0, 1'b0, d);
      mode = 0;
      for (int k = 0; k < 3000; k++) begin
         if ((k % 50) == 0) mode = $urandom_range(0, 3);
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 79) != 0);
         case (mode)
            0:       d = ~d;
            1:       if ((k % 2) == 0) d = ~d;
            2:       if ($urandom_range(0, 1) == 1) d = ~d;
            default: if ($urandom_range(0, 19) == 0) d = ~d;
         endcase
         tick(r, e, d);
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs[i] !== expv(i)) $display("FAIL random_model inst%0d cyc%0d: got %h expected %h", i, cyc, obs[i], expv(i));
            else n_pass++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; dep_clk = 1'b0;
      @(negedge clk);
      test_reset();
      test_toggle_run();
      test_gap_err();
      test_stall();
      test_reset_mid();
      test_en_drop();
      test_timeout_edge();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dep_clk_edge_monitor.md
# dep_clk_edge_monitor

Checker stage downstream of the DPI-driven dependent-clock generator. Samples the dependent clock `dep_clk` in the `clk` domain and detects every edge in either direction. Counts edges, checks that consecutive edges are exactly `PERIOD` clk cycles apart, and flags completion after `TARGET` edges. A timing violation or a stalled dependent clock raises a sticky error. Used by regression benches in place of hand-written `always @(edge …)` checkers.

## Interface

Parameters:
- `CNT_W`, 8: width of the edge counter and the gap counter.
- `TARGET`, 20: number of edges counted before `done`; range 1..2^CNT_W-1.
- `PERIOD`, 1: required spacing between consecutive edges, in clk cycles; range 1..TIMEOUT-1.
- `TIMEOUT`, 16: gap length, in clk cycles, at which an absent edge is declared a stall; must be ≤ 2^CNT_W-1.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: arm or run the monitor; deasserting it returns to IDLE.
- `dep_clk` in 1: dependent clock under observation; already synchronous to `clk`.
- `edge_valid` out 1: one-cycle pulse per detected edge.
- `edge_rise` out 1: polarity of the pulsed edge (1 = rising); valid only with `edge_valid`.
- `edge_count` out CNT_W: number of edges counted since arming.
- `gap_err` out 1: sticky; an edge arrived with a gap ≠ `PERIOD`.
- `stall_err` out 1: sticky; the gap reached `TIMEOUT` with no edge.
- `done` out 1: sticky; `edge_count` reached `TARGET` with no error.
- `busy` out 1: high in the ARM and RUN states.

## Operation

- Registers:
  - `prev`: last sampled value of `dep_clk`.
  - `gap`: clk cycles since the last edge; saturates at all-ones.
  - `edge_count`.
  - State.
- Edge detection: `edge = (dep_clk != prev)` in ARM and RUN. `prev <= dep_clk` every cycle in which `en` = 1.
- State machine:
  - IDLE
    - On `en` = 1: load `prev`, clear `gap`, `edge_count`, `gap_err`, `stall_err` and `done`; go to ARM.
  - ARM: waiting for the first edge.
    - First edge: pulse `edge_valid`, `edge_count` = 1, `gap` = 1, go to RUN. This edge is not gap-checked.
    - `gap` reaching `TIMEOUT` without an edge sets `stall_err`; go to FAIL.
  - RUN, on an edge:
    - Pulse `edge_valid`.
    - If `gap` ≠ `PERIOD`: set `gap_err`, go to FAIL. `edge_count` is not incremented.
    - Otherwise increment `edge_count`.
    - `gap` restarts at 1 on every edge.
  - RUN, on a non-edge cycle:
    - `gap` increments.
    - At `gap == TIMEOUT`: set `stall_err`, go to FAIL.
  - In both ARM and RUN, when the counted edge makes `edge_count == TARGET`: set `done`, go to DONE.
  - DONE and FAIL are terminal:
    - Flags hold.
    - `edge_valid` still pulses on edges.
    - `edge_count` and `gap` freeze.
    - Only `rst` or an `en` deassertion leaves these states.
- `en` deasserted in any state: go to IDLE. Flags and `edge_count` hold their values until the next arm.
- Simultaneous events:
  - An edge on the same cycle `gap` reaches `TIMEOUT`: the edge wins and is gap-checked, so the result is `gap_err`, not `stall_err`.
  - An error edge that would also reach `TARGET`: the error wins and `done` stays 0.
- Reset mid-operation: `rst` has priority over everything. All state returns to reset values on the next edge; no flag survives.

## Timing

- Reset values:
  - State = IDLE; `prev` = 0; `gap` = 0.
  - `edge_valid` = 0; `edge_rise` = 0; `edge_count` = 0.
  - `gap_err` = 0; `stall_err` = 0; `done` = 0; `busy` = 0.
- All outputs are registered.
- `edge_valid` and `edge_rise` assert in the cycle after the posedge at which the changed `dep_clk` is first sampled. Latency is 1 cycle.
- `edge_count`, `done`, `gap_err` and `stall_err` update in the same cycle as the corresponding `edge_valid`.
- `busy` rises 1 cycle after `en` rises. It falls 1 cycle after `en` falls or after the terminal transition.
- A `dep_clk` toggle aligned with the `en` rising edge is absorbed into `prev` and is not counted.

## Test plan

- `dep_clk` toggles every cycle, `PERIOD` = 1, `TARGET` = 20 → 20 `edge_valid` pulses with alternating `edge_rise`. `done` = 1 with the 20th pulse, `edge_count` = 20, no errors.
- `PERIOD` = 2, `dep_clk` toggles every 2 cycles, then one toggle after 3 cycles at edge 7 → `gap_err` = 1 with the 7th pulse. `edge_count` stays 6 and the state is FAIL.
- `dep_clk` held constant after arming, `TIMEOUT` = 16 → `stall_err` = 1 exactly 16 cycles after arming; `done` = 0.
- `rst` asserted after edge 10 of a good run → the next cycle shows every output at its reset value. Re-arming completes a full 20-edge run.
- `en` dropped after edge 5, then re-raised → `edge_count` holds 5 while in IDLE and clears to 0 on re-arm. An edge concurrent with the `en` rise is not counted.
- Edge arriving exactly when `gap` = `TIMEOUT` (`PERIOD` = 1) → `gap_err` = 1, `stall_err` = 0.
